// File: rtl/axi_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi_arb_pkg
//   Shared types for the AXI-Lite request arbiter: scheduler state encoding,
//   bus widths and the latched request record handed to the master.
// ---------------------------------------------------------------------------
package axi_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // One requester's transaction as captured at grant time.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } arb_req_t;

endpackage : axi_arb_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority encoder. Searches req upward starting
//   at ptr, wrapping from NUM_REQ-1 back to 0, and reports the first set bit.
//
//   req    in   NUM_REQ  request vector
//   ptr    in   IDX_W    index with highest priority this round
//   grant  out  NUM_REQ  one-hot grant (all zero when nothing requested)
//   idx    out  IDX_W    binary index of the granted requester
//   any    out  1        at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr and i are both below NUM_REQ, so one subtraction wraps.
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= NUM_L) begin
                sum = sum - NUM_L;
            end
            cand = sum[IDX_W-1:0];
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule : rr_pick

// File: rtl/axi_lite_req_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_req_arbiter
//   Round-robin scheduler sharing one axi_lite_master command port between
//   NUM_REQ requesters. One transaction at a time: grant, issue a single
//   start pulse, wait for the matching response handshake (or time out),
//   then return the result to the granted requester only.
//
//   aclk, areset_n          clock, asynchronous active-low reset
//   req_valid/write         per-requester request and direction (1=write)
//   req_addr/wdata/wstrb    packed per-requester payload, requester i at [W*i +: W]
//   req_ready               one-hot acceptance pulse (ISSUE)
//   rsp_valid               one-hot completion pulse (RESP)
//   rsp_rdata, rsp_err      result, held between responses (err=1 on timeout)
//   start_read/start_write  one-cycle command pulse to the master
//   addr, data, wstrb       command payload to the master, held after issue
//   m_bvalid/m_bready       write-response handshake observed on the master
//   m_rvalid/m_rready       read-data handshake observed on the master
//   m_rdata                 master read data
//   busy                    scheduler not idle
// ---------------------------------------------------------------------------
module axi_lite_req_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = $clog2(TIMEOUT+1)
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_W-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      start_read,
    output logic                      start_write,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         data,
    output logic [STRB_W-1:0]         wstrb,
    input  logic                      m_bvalid,
    input  logic                      m_bready,
    input  logic                      m_rvalid,
    input  logic                      m_rready,
    input  logic [DATA_W-1:0]         m_rdata,
    output logic                      busy
);

    localparam int               IDX_W   = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ-1);
    // The counter is compared after incrementing, so RESP follows ISSUE by
    // exactly TIMEOUT cycles when no handshake arrives.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT-1);

    arb_state_e state, state_next;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    arb_req_t           cur;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic               rsp_err_q;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic               wr_hs;
    logic               rd_hs;
    logic               op_done;
    logic               to_hit;

    arb_req_t           req_vec [NUM_REQ];

    // Unpack the flat request buses into one record per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_vec[i].write = req_write[i];
        assign req_vec[i].addr  = req_addr[i*ADDR_W +: ADDR_W];
        assign req_vec[i].wdata = req_wdata[i*DATA_W +: DATA_W];
        assign req_vec[i].wstrb = req_wstrb[i*STRB_W +: STRB_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Only the handshake matching the granted direction completes it.
    assign wr_hs   = m_bvalid & m_bready;
    assign rd_hs   = m_rvalid & m_rready;
    assign op_done = cur.write ? wr_hs : rd_hs;
    assign cnt_inc = cnt + CNT_W'(1);
    assign to_hit  = (cnt_inc == TO_LAST);

    // ---------------------------------------------------------------- FSM
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pick_any) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (op_done || to_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rr_ptr      <= '0;
            gnt_idx     <= '0;
            gnt_oh      <= '0;
            cur         <= '0;
            cnt         <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_idx <= pick_idx;
                        gnt_oh  <= pick_grant;
                        cur     <= req_vec[pick_idx];
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    // Completion takes precedence over a coincident timeout.
                    if (op_done) begin
                        rsp_rdata_q <= cur.write ? '0 : m_rdata;
                        rsp_err_q   <= 1'b0;
                    end else if (to_hit) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                RESP: begin
                    rr_ptr <= (gnt_idx == IDX_MAX) ? '0 : gnt_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------- outputs
    // Pulses decode directly from state so reset clears them immediately.
    assign req_ready   = (state == ISSUE) ? gnt_oh : '0;
    assign rsp_valid   = (state == RESP)  ? gnt_oh : '0;
    assign start_write = (state == ISSUE) &  cur.write;
    assign start_read  = (state == ISSUE) & ~cur.write;
    assign addr        = cur.addr;
    assign data        = cur.wdata;
    assign wstrb       = cur.wstrb;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state != IDLE);

endmodule : axi_lite_req_arbiter

// File: tb/tb_axi_lite_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_req_arbiter
//   Directed bench for a two-requester arbiter with TIMEOUT=16. Inputs are
//   driven and outputs sampled 1 ns after the rising edge; a negedge monitor
//   tallies start and response pulses for end-of-run totals.
// ---------------------------------------------------------------------------
module tb_axi_lite_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 16;

    logic                 aclk;
    logic                 areset_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_write;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]  req_wstrb;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 start_read;
    logic                 start_write;
    logic [31:0]          addr;
    logic [31:0]          data;
    logic [3:0]           wstrb;
    logic                 m_bvalid;
    logic                 m_bready;
    logic                 m_rvalid;
    logic                 m_rready;
    logic [31:0]          m_rdata;
    logic                 busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_start_wr = 0;
    int n_start_rd = 0;
    int n_overlap = 0;
    int n_rsp = 0;

    axi_lite_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .aclk        (aclk),
        .areset_n    (areset_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .start_read  (start_read),
        .start_write (start_write),
        .addr        (addr),
        .data        (data),
        .wstrb       (wstrb),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready),
        .m_rdata     (m_rdata),
        .busy        (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (start_write) n_start_wr <= n_start_wr + 1;
        if (start_read)  n_start_rd <= n_start_rd + 1;
        if (start_write && start_read) n_overlap <= n_overlap + 1;
        if (rsp_valid != '0) n_rsp <= n_rsp + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int early;
        logic [1:0]  exp_oh;
        logic [31:0] exp_rd;

        areset_n  = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        m_bvalid  = 1'b0;
        m_bready  = 1'b0;
        m_rvalid  = 1'b0;
        m_rready  = 1'b0;
        m_rdata   = '0;
        tick();
        tick();

        // Reset state.
        check("rst_busy",      32'(busy),        32'h0);
        check("rst_req_ready", 32'(req_ready),   32'h0);
        check("rst_rsp_valid", 32'(rsp_valid),   32'h0);
        check("rst_start",     32'({start_write, start_read}), 32'h0);
        check("rst_addr",      addr,             32'h0);
        areset_n = 1'b1;
        tick();

        // 1. Single write from requester 0, response 3 cycles after start.
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr[31:0]  = 32'h0000_0004;
        req_wdata[31:0] = 32'h0000_00A5;
        req_wstrb[3:0]  = 4'hF;
        tick();                                   // ISSUE
        check("t1_ready",    32'(req_ready),   32'h1);
        check("t1_start_wr", 32'(start_write), 32'h1);
        check("t1_start_rd", 32'(start_read),  32'h0);
        check("t1_addr",     addr,             32'h0000_0004);
        check("t1_data",     data,             32'h0000_00A5);
        check("t1_wstrb",    32'(wstrb),       32'hF);
        check("t1_busy",     32'(busy),        32'h1);
        req_valid = 2'b00;
        tick();                                   // WAIT +1
        check("t1_pulse_len", 32'(start_write), 32'h0);
        tick();                                   // WAIT +2
        tick();                                   // WAIT +3
        check("t1_no_early", 32'(rsp_valid), 32'h0);
        m_bvalid = 1'b1;
        m_bready = 1'b1;
        tick();                                   // RESP
        m_bvalid = 1'b0;
        m_bready = 1'b0;
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_err",   32'(rsp_err),   32'h0);
        check("t1_rsp_rdata", rsp_rdata,      32'h0);
        check("t1_hold_addr", addr,           32'h0000_0004);
        tick();                                   // IDLE
        check("t1_rsp_pulse", 32'(rsp_valid), 32'h0);
        check("t1_idle",      32'(busy),      32'h0);

        // 2. Single read from requester 1.
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr[63:32] = 32'h0000_0008;
        tick();                                   // ISSUE
        check("t2_ready",    32'(req_ready),   32'h2);
        check("t2_start_rd", 32'(start_read),  32'h1);
        check("t2_start_wr", 32'(start_write), 32'h0);
        check("t2_addr",     addr,             32'h0000_0008);
        req_valid = 2'b00;
        tick();                                   // WAIT
        m_rvalid = 1'b1;
        m_rready = 1'b1;
        m_rdata  = 32'h0000_003C;
        tick();                                   // RESP
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rdata  = '0;
        check("t2_rsp_valid", 32'(rsp_valid), 32'h2);
        check("t2_rsp_rdata", rsp_rdata,      32'h0000_003C);
        check("t2_rsp_err",   32'(rsp_err),   32'h0);
        tick();                                   // IDLE
        check("t2_rdata_hold", rsp_rdata, 32'h0000_003C);

        // 3. Contention: both held, req0 writes, req1 reads; grants alternate.
        req_write = 2'b01;
        req_addr  = {32'h0000_0200, 32'h0000_0100};
        req_wdata = {32'h0000_0000, 32'h0000_0011};
        req_wstrb = {4'h0, 4'h3};
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_rd = (k % 2 == 0) ? 32'h0 : 32'hC0DE_0000 + 32'(k);
            tick();                               // ISSUE
            check("t3_ready",    32'(req_ready),   32'(exp_oh));
            check("t3_start_wr", 32'(start_write), 32'(exp_oh[0]));
            check("t3_addr",     addr, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            tick();                               // WAIT
            if (k % 2 == 0) begin
                m_bvalid = 1'b1;
                m_bready = 1'b1;
                m_rdata  = 32'hDEAD_BEEF;
            end else begin
                m_rvalid = 1'b1;
                m_rready = 1'b1;
                m_rdata  = 32'hC0DE_0000 + 32'(k);
            end
            tick();                               // RESP
            m_bvalid = 1'b0;
            m_bready = 1'b0;
            m_rvalid = 1'b0;
            m_rready = 1'b0;
            m_rdata  = '0;
            check("t3_rsp_valid", 32'(rsp_valid), 32'(exp_oh));
            check("t3_rsp_rdata", rsp_rdata,      exp_rd);
            tick();                               // IDLE
        end
        req_valid = 2'b00;

        // 5. Wrong-type handshake on a pending read is ignored.
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr[31:0] = 32'h0000_0010;
        tick();                                   // ISSUE
        check("t5_ready",    32'(req_ready),  32'h1);
        check("t5_start_rd", 32'(start_read), 32'h1);
        req_valid = 2'b00;
        tick();                                   // WAIT
        m_bvalid = 1'b1;
        m_bready = 1'b1;
        tick();                                   // still WAIT
        m_bvalid = 1'b0;
        m_bready = 1'b0;
        check("t5_wrong_type", 32'(rsp_valid), 32'h0);
        check("t5_busy",       32'(busy),      32'h1);
        m_rvalid = 1'b1;
        m_rready = 1'b1;
        m_rdata  = 32'h1234_5678;
        tick();                                   // RESP
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rdata  = '0;
        check("t5_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t5_rsp_rdata", rsp_rdata,      32'h1234_5678);
        tick();                                   // IDLE

        // 4. Timeout on a write from requester 1: RESP exactly TIMEOUT cycles after ISSUE.
        req_valid = 2'b10;
        req_write = 2'b10;
        req_addr[63:32] = 32'h0000_0040;
        tick();                                   // ISSUE
        check("t4_ready",    32'(req_ready),   32'h2);
        check("t4_start_wr", 32'(start_write), 32'h1);
        req_valid = 2'b00;
        early = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            if (rsp_valid != '0 || !busy) early++;
        end
        check("t4_no_early_rsp", 32'(early), 32'h0);
        tick();                                   // ISSUE + TIMEOUT
        check("t4_rsp_valid", 32'(rsp_valid), 32'h2);
        check("t4_rsp_err",   32'(rsp_err),   32'h1);
        check("t4_rsp_rdata", rsp_rdata,      32'h0);
        m_bvalid = 1'b1;
        m_bready = 1'b1;
        tick();                                   // IDLE, late response present
        check("t4_idle",       32'(busy),      32'h0);
        check("t4_late_ign",   32'(rsp_valid), 32'h0);
        tick();
        m_bvalid = 1'b0;
        m_bready = 1'b0;
        check("t4_still_idle", 32'(busy),    32'h0);
        check("t4_err_hold",   32'(rsp_err), 32'h1);

        // Completion in the timeout cycle wins.
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr[31:0] = 32'h0000_0050;
        tick();                                   // ISSUE
        check("tie_ready", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
        end
        m_rvalid = 1'b1;
        m_rready = 1'b1;
        m_rdata  = 32'h0000_5A5A;
        tick();                                   // RESP
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rdata  = '0;
        check("tie_rsp_valid", 32'(rsp_valid), 32'h1);
        check("tie_rsp_err",   32'(rsp_err),   32'h0);
        check("tie_rsp_rdata", rsp_rdata,      32'h0000_5A5A);
        tick();                                   // IDLE

        // 6. Reset during WAIT abandons the transaction and resets rr_ptr.
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr[63:32] = 32'h0000_0030;
        tick();                                   // ISSUE
        check("t6_ready", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        tick();                                   // WAIT
        tick();                                   // WAIT
        areset_n = 1'b0;
        #1;
        check("t6_busy",      32'(busy),      32'h0);
        check("t6_addr",      addr,           32'h0);
        check("t6_data",      data,           32'h0);
        check("t6_wstrb",     32'(wstrb),     32'h0);
        check("t6_rsp_rdata", rsp_rdata,      32'h0);
        check("t6_rsp_err",   32'(rsp_err),   32'h0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t6_start",     32'({start_write, start_read}), 32'h0);
        tick();
        areset_n = 1'b1;
        m_rvalid = 1'b1;
        m_rready = 1'b1;
        m_rdata  = 32'h0000_0077;
        tick();
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rdata  = '0;
        check("t6_no_rsp", 32'(rsp_valid), 32'h0);
        check("t6_idle",   32'(busy),      32'h0);
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr[31:0] = 32'h0000_0060;
        tick();                                   // ISSUE
        check("t6_ptr_reset", 32'(req_ready), 32'h1);
        check("t6_addr_new",  addr,           32'h0000_0060);
        req_valid = 2'b00;
        tick();                                   // WAIT
        m_rvalid = 1'b1;
        m_rready = 1'b1;
        m_rdata  = 32'h0000_ABCD;
        tick();                                   // RESP
        m_rvalid = 1'b0;
        m_rready = 1'b0;
        m_rdata  = '0;
        check("t6_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t6_rsp_rdata", rsp_rdata,      32'h0000_ABCD);
        tick();

        // Pulse totals over the whole run.
        check("tot_start_wr", 32'(n_start_wr), 32'd5);
        check("tot_start_rd", 32'(n_start_rd), 32'd8);
        check("tot_overlap",  32'(n_overlap),  32'd0);
        check("tot_rsp",      32'(n_rsp),      32'd12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_axi_lite_req_arbiter

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
Round-robin scheduler that shares the single axi_lite_master port (start_read/start_write, addr/data/wstrb) between NUM_REQ requesters, such as a boot-time UART configuration sequencer and a software/debug port. It sits in front of axi_lite_master in top. It serialises transactions, issues one start pulse per transaction, and waits for the AXI response handshake. It returns read data or a timeout error to the granted requester only.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT, 1024, cycles allowed in WAIT before forced error completion (>=4)
CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
aclk  in  1  clock
areset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request, held until req_ready
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*32  packed addresses, requester i at [32i+:32]
req_wdata  in  NUM_REQ*32  packed write data
req_wstrb  in  NUM_REQ*4  packed byte strobes
req_ready  out  NUM_REQ  one-hot acceptance pulse
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  32  read data, valid with rsp_valid
rsp_err  out  1  1=timeout, valid with rsp_valid
start_read  out  1  to master, 1-cycle pulse
start_write  out  1  to master, 1-cycle pulse
addr  out  32  to master, held from ISSUE through WAIT
data  out  32  to master, held from ISSUE through WAIT
wstrb  out  4  to master, held from ISSUE through WAIT
m_bvalid, m_bready  in  1 each  write-response handshake observed on master
m_rvalid, m_rready  in  1 each  read-data handshake observed on master
m_rdata  in  32  master read data (debug_rdata)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0. All outputs 0, including addr/data/wstrb and rsp_rdata. Reset mid-transaction abandons it silently; no rsp_valid is issued.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, pick the first set bit searching from rr_ptr upward with wrap, NUM_REQ-1 to 0.
  - Register grant index g and the selected write/addr/wdata/wstrb.
  - Go to ISSUE.
- ISSUE (exactly 1 cycle):
  - req_ready[g]=1.
  - start_write=1 if write, else start_read=1. Never both.
  - Timeout counter cleared.
  - Go to WAIT.
- WAIT:
  - A write completes when m_bvalid&m_bready. A read completes when m_rvalid&m_rready, and m_rdata is captured that cycle.
  - Only the handshake type matching the granted op counts.
  - Counter increments each cycle. When it reaches TIMEOUT-1 without completion, go to RESP with err=1 and rdata=0.
  - If completion and timeout occur in the same cycle, completion wins (err=0).
- RESP (1 cycle):
  - rsp_valid[g]=1, plus rsp_rdata and rsp_err.
  - For a write, rsp_rdata=0.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Go to IDLE.
- Latency: req_valid sampled in IDLE at cycle T gives req_ready and start at T+1, and rsp_valid 1 cycle after the completing handshake. Minimum per-transaction turnaround is 4 cycles (IDLE, ISSUE, WAIT, RESP).
- Handshakes seen outside WAIT (e.g. a late response after a timeout) are ignored.
- A requester dropping req_valid before its grant is allowed; it simply loses arbitration. After req_ready the request is already latched, so inputs may change.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.
- rsp_rdata and rsp_err hold their values between responses. rsp_valid and req_ready are pulses only.

Decomposition:
- Package axi_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
  - localparam ADDR_W=32, DATA_W=32, STRB_W=4;
  - a packed struct arb_req_t {write, addr, wdata, wstrb}.
- One sub-module, rr_pick: combinational round-robin priority encoder (req vector, ptr -> one-hot grant, index, any).
- The FSM, latch and timeout counter stay in the parent.

Test Plan:
1. Single write: req0 write addr=0x0000_0004, wdata=0x0000_00A5, wstrb=0xF; m_bvalid&m_bready 3 cycles after start -> start_write pulse 1 cycle with addr=0x4, data=0xA5; rsp_valid=01, rsp_err=0; no start_read.
2. Single read: req1 read addr=0x8; m_rvalid&m_rready with m_rdata=0x0000_003C -> start_read pulse; rsp_valid=10, rsp_rdata=0x3C, rsp_err=0.
3. Contention: req0 and req1 held continuously, 6 transactions -> grants alternate 0,1,0,1,0,1; exactly one start pulse per transaction; never overlapping.
4. Timeout: TIMEOUT=16, no response handshake -> rsp_valid 16 cycles after ISSUE with rsp_err=1 and rsp_rdata=0; a later m_bvalid&m_bready is ignored; busy returns to 0.
5. Wrong-type handshake: read pending, m_bvalid&m_bready pulse -> no completion; a subsequent m_rvalid&m_rready completes it.
6. Reset mid-WAIT: assert areset_n=0 during WAIT -> all outputs 0 immediately; no rsp_valid; the next request is granted starting from requester 0.
